spi_dac_rx: RTL and testbench

- SPI peripheral-side receiver for the 32-bit DAC command frame (AD5628-style layout) driven by our spi_dac master.
- Oversamples cs/sclk/mosi in the clk100mhz domain, shifts in frames on sclk falling edges, decodes command/address/data, and maintains per-channel input and DAC registers plus the internal-reference enable.
- Used as a behavioural-accurate DAC model in benches and as a loopback checker on-board.

---
 rtl/spi_dac_pkg.sv | 31 +++
 rtl/spi_dac_rx_if.sv | 16 +
 rtl/spi_in_sync.sv | 51 +++++
 rtl/spi_dac_rx.sv | 171 +++++++++++++++++
 tb/tb_spi_dac_rx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_dac_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_dac_pkg
// Brief    : Shared frame layout and command codes for the spi_dac master and
//            the spi_dac_rx receiver model.
// Revision : 1.0 - initial release
// ============================================================================
package spi_dac_pkg;

    typedef enum logic [3:0] {
        CMD_WR_IN      = 4'h0,
        CMD_UPD        = 4'h1,
        CMD_WR_UPD_ALL = 4'h2,
        CMD_WR_UPD     = 4'h3,
        CMD_REF        = 4'h8
    } dac_cmd_e;

    localparam logic [3:0]  ADDR_ALL    = 4'hF;
    localparam int          FRAME_BITS  = 32;
    localparam int          CMD_LSB     = 24;
    localparam int          ADDR_LSB    = 20;
    localparam int          DATA_LSB    = 8;
    localparam int          REF_BIT     = 0;
    localparam logic [5:0]  CNT_MAX     = 6'd33;

    localparam logic [31:0] SETUP_WORD  = 32'h0800_0001;
    localparam logic [11:0] DATA_PREFIX = 12'h030;

endpackage
`default_nettype wire

// File: rtl/spi_dac_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_dac_rx_if
// Brief    : Three-wire SPI bus between the DAC master and the receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_dac_rx_if;
    logic cs;
    logic sclk;
    logic mosi;

    modport master (output cs, output sclk, output mosi);
    modport slave  (input  cs, input  sclk, input  mosi);
endinterface
`default_nettype wire

// File: rtl/spi_in_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_in_sync
// Brief    : Two-flop synchronizer for cs/sclk/mosi plus cs/sclk edge detect.
// Revision : 1.0 - initial release
// ============================================================================
module spi_in_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic cs,
    input  wire logic sclk,
    input  wire logic mosi,
    output logic      cs_s,
    output logic      mosi_s,
    output logic      sclk_fall,
    output logic      cs_fall,
    output logic      cs_rise
);

    // Bit order in all vectors: [2]=cs, [1]=sclk, [0]=mosi; prev keeps cs/sclk only.
    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic [1:0] prev_q, prev_d;

    always_comb begin
        meta_d = {cs, sclk, mosi};
        sync_d = meta_q;
        prev_d = sync_q[2:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign cs_s      = sync_q[2];
    assign mosi_s    = sync_q[0];
    assign sclk_fall =  prev_q[0] & ~sync_q[1];
    assign cs_fall   =  prev_q[1] & ~sync_q[2];
    assign cs_rise   = ~prev_q[1] &  sync_q[2];

endmodule
`default_nettype wire

// File: rtl/spi_dac_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_dac_rx
// Brief    : Oversampling SPI receiver and register model of an 8-channel DAC.
// Revision : 1.0 - initial release
// ============================================================================
module spi_dac_rx
    import spi_dac_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
) (
    input  wire logic               clk100mhz,
    input  wire logic               rst,
    spi_dac_rx_if.slave             spi,
    output logic [NUM_CH*DATA_W-1:0] dac_codes,
    output logic                    ref_en,
    output logic [FRAME_BITS-1:0]   frame_word,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    cmd_err
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DECODE    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   frame_word_q, frame_word_d;
    logic [DATA_W-1:0]       in_q [NUM_CH];
    logic [DATA_W-1:0]       in_d [NUM_CH];
    logic [DATA_W-1:0]       dac_q[NUM_CH];
    logic [DATA_W-1:0]       dac_d[NUM_CH];
    logic                    ref_en_q, ref_en_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    cmd_err_q, cmd_err_d;

    logic                    w_cs_s, w_mosi_s, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic [3:0]              w_cmd, w_addr;
    logic [DATA_W-1:0]       w_data;
    logic                    w_addr_ok;

    spi_in_sync u_sync (
        .clk       (clk100mhz),
        .rst       (rst),
        .cs        (spi.cs),
        .sclk      (spi.sclk),
        .mosi      (spi.mosi),
        .cs_s      (w_cs_s),
        .mosi_s    (w_mosi_s),
        .sclk_fall (w_sclk_fall),
        .cs_fall   (w_cs_fall),
        .cs_rise   (w_cs_rise)
    );

    assign w_cmd     = shift_q[CMD_LSB  +: 4];
    assign w_addr    = shift_q[ADDR_LSB +: 4];
    assign w_data    = shift_q[DATA_LSB +: DATA_W];
    assign w_addr_ok = (w_addr == ADDR_ALL) || (int'(w_addr) < NUM_CH);

    // cs_rise is tested before sclk_fall so a coincident edge is not counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            WAIT_IDLE: if (w_cs_s) state_d = IDLE;
            IDLE: begin
                if (w_cs_fall) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    state_d = DECODE;
                end else if (w_sclk_fall) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], w_mosi_s};
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 6'd1;
                end
            end
            DECODE:  state_d = IDLE;
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        in_d          = in_q;
        dac_d         = dac_q;
        ref_en_d      = ref_en_q;
        frame_word_d  = frame_word_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        cmd_err_d     = 1'b0;
        if (state_q == DECODE) begin
            if (cnt_q != 6'(FRAME_BITS)) begin
                frame_err_d = 1'b1;
            end else begin
                frame_word_d  = shift_q;
                frame_valid_d = 1'b1;
                case (w_cmd)
                    CMD_REF: ref_en_d = shift_q[REF_BIT];
                    CMD_WR_IN, CMD_UPD, CMD_WR_UPD_ALL, CMD_WR_UPD: begin
                        if (!w_addr_ok) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            for (int n = 0; n < NUM_CH; n++) begin
                                if (w_addr == ADDR_ALL || w_addr == 4'(n)) begin
                                    if (w_cmd == CMD_UPD) dac_d[n] = in_q[n];
                                    else                  in_d[n]  = w_data;
                                    if (w_cmd == CMD_WR_UPD) dac_d[n] = w_data;
                                end
                            end
                            // Global update sees the freshly written input register.
                            if (w_cmd == CMD_WR_UPD_ALL) dac_d = in_d;
                        end
                    end
                    default: cmd_err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state_q       <= WAIT_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            frame_word_q  <= '0;
            ref_en_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                in_q[n]  <= '0;
                dac_q[n] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            frame_word_q  <= frame_word_d;
            ref_en_q      <= ref_en_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            cmd_err_q     <= cmd_err_d;
            in_q          <= in_d;
            dac_q         <= dac_d;
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_pack
        assign dac_codes[n*DATA_W +: DATA_W] = dac_q[n];
    end

    assign ref_en      = ref_en_q;
    assign frame_word  = frame_word_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign cmd_err     = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_dac_rx
// Brief    : Directed and random SPI frames against a register-level DAC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_dac_rx;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;
    localparam int HALF   = 5;

    logic                     clk100mhz = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] dac_codes;
    logic                     ref_en;
    logic [31:0]              frame_word;
    logic                     frame_valid, frame_err, cmd_err;

    spi_dac_rx_if spi ();

    spi_dac_rx #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk100mhz   (clk100mhz),
        .rst         (rst),
        .spi         (spi),
        .dac_codes   (dac_codes),
        .ref_en      (ref_en),
        .frame_word  (frame_word),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .cmd_err     (cmd_err)
    );

    always #5 clk100mhz = ~clk100mhz;

    int          errors = 0;
    int          checks = 0;
    logic [11:0] in_m [NUM_CH];
    logic [11:0] dac_m[NUM_CH];
    logic        ref_m;
    logic [31:0] word_m;
    int          exp_v, exp_e, exp_c;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NUM_CH; n++) begin
            in_m[n]  = '0;
            dac_m[n] = '0;
        end
        ref_m  = 1'b0;
        word_m = '0;
    endtask

    // DAC register behaviour from the command table, one frame at a time.
    task automatic model_frame(input int nbits, input logic [63:0] val);
        logic [31:0] f;
        int cmd, addr;
        exp_v = 0; exp_e = 0; exp_c = 0;
        if (nbits != 32) begin
            exp_e = 1;
            return;
        end
        f      = val[31:0];
        cmd    = int'(f[27:24]);
        addr   = int'(f[23:20]);
        exp_v  = 1;
        word_m = f;
        if (cmd == 8) begin
            ref_m = f[0];
        end else if (cmd > 3 || (addr >= NUM_CH && addr != 15)) begin
            exp_c = 1;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (addr == 15 || addr == n) begin
                    if (cmd == 1) dac_m[n] = in_m[n];
                    else          in_m[n]  = f[19:8];
                    if (cmd == 3) dac_m[n] = f[19:8];
                end
            end
            if (cmd == 2) for (int n = 0; n < NUM_CH; n++) dac_m[n] = in_m[n];
        end
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] packed_dac();
        logic [NUM_CH*DATA_W-1:0] p;
        for (int n = 0; n < NUM_CH; n++) p[n*DATA_W +: DATA_W] = dac_m[n];
        return p;
    endfunction

    task automatic spi_begin();
        @(negedge clk100mhz);
        spi.cs   = 1'b0;
        spi.sclk = 1'b1;
        repeat (HALF) @(negedge clk100mhz);
    endtask

    task automatic spi_bits(input int nbits, input logic [63:0] val);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi.mosi = val[i];
            repeat (HALF) @(negedge clk100mhz);
            spi.sclk = 1'b0;
            repeat (HALF) @(negedge clk100mhz);
            spi.sclk = 1'b1;
        end
    endtask

    task automatic spi_end();
        repeat (HALF) @(negedge clk100mhz);
        spi.cs = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        int nv = 0, ne = 0, nc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk100mhz);
            if (frame_valid === 1'b1) nv++;
            if (frame_err   === 1'b1) ne++;
            if (cmd_err     === 1'b1) nc++;
        end
        chk({tag, "/valid"},   128'(nv), 128'(exp_v));
        chk({tag, "/ferr"},    128'(ne), 128'(exp_e));
        chk({tag, "/cmderr"},  128'(nc), 128'(exp_c));
        chk({tag, "/word"},    128'(frame_word), 128'(word_m));
        chk({tag, "/dac"},     128'(dac_codes),  128'(packed_dac()));
        chk({tag, "/ref"},     128'(ref_en),     128'(ref_m));
    endtask

    task automatic send(input string tag, input int nbits, input logic [63:0] val);
        spi_begin();
        spi_bits(nbits, val);
        spi_end();
        model_frame(nbits, val);
        check_frame(tag);
    endtask

    initial begin
        logic [31:0] f;
        int          nbits;
        int          sel;
        rst      = 1'b1;
        spi.cs   = 1'b1;
        spi.sclk = 1'b1;
        spi.mosi = 1'b0;
        model_reset();
        repeat (5) @(negedge clk100mhz);
        rst = 1'b0;
        repeat (10) @(negedge clk100mhz);
        chk("reset/dac",    128'(dac_codes),   128'(0));
        chk("reset/ref",    128'(ref_en),      128'(0));
        chk("reset/word",   128'(frame_word),  128'(0));
        chk("reset/valid",  128'(frame_valid), 128'(0));
        chk("reset/ferr",   128'(frame_err),   128'(0));
        chk("reset/cmderr", 128'(cmd_err),     128'(0));

        send("setup",     32, 64'h0800_0001);
        send("wr_upd0",   32, 64'h030A_AA00);
        send("wr_in2",    32, 64'h0025_5500);
        send("upd2",      32, 64'h0120_0000);
        send("bcast",     32, 64'h03F1_2300);
        send("bad_addr",  32, 64'h0391_2300);
        send("wr_all",    32, 64'h0254_5600);
        send("bad_cmd",   32, 64'h0530_0000);
        send("short20",   20, 64'h0_3F77);
        send("long33",    33, 64'h1_03F7_7700);

        // Reset in the middle of a frame; the tail must never be decoded.
        spi_begin();
        spi_bits(10, 64'h0000_0000_03F4_5600 >> 22);
        @(negedge clk100mhz);
        rst = 1'b1;
        repeat (3) @(negedge clk100mhz);
        rst = 1'b0;
        model_reset();
        spi_bits(22, 64'h0000_0000_03F4_5600);
        spi_end();
        exp_v = 0; exp_e = 0; exp_c = 0;
        check_frame("rst_mid");
        send("after_rst", 32, 64'h0301_2300);

        for (int k = 0; k < 30; k++) begin
            f   = $urandom;
            sel = int'($urandom_range(0, 6));
            if (sel <= 3)      f[27:24] = 4'(sel);
            else if (sel == 4) f[27:24] = 4'h8;
            f[23:20] = 4'($urandom_range(0, 15));
            nbits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 40)) : 32;
            send("rand", nbits, {$urandom, f});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
